// File: rtl/apb_slave_mem.sv
// APB completer backed by a DEPTH x DATA_W register file, with a fixed number of
// wait states per transfer and pslverr on addresses at or beyond DEPTH.
module apb_slave_mem #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              wr_pulse,
    output logic              rd_pulse
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [ADDR_W:0]  DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_V  = CNT_W'(WAIT_CYCLES);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx_q;
    logic              write_q;
    logic              err_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              setup_err;
    logic [IDX_W-1:0]  setup_idx;

    // Full address is range-checked so out-of-range addresses never alias low entries.
    assign setup_err = ({1'b0, paddr} >= DEPTH_V);
    assign setup_idx = paddr[IDX_W-1:0];

    // Handshake: a transfer completes on the edge where psel, penable and pready are
    // all high; pready rises once the wait counter is exhausted and stays high until
    // the master raises penable or drops psel. pslverr is meaningful only with pready.
    assign pready  = (state == S_ACCESS) && (cnt == '0);
    assign pslverr = pready & err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            prdata   <= '0;
            wr_pulse <= 1'b0;
            rd_pulse <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            wr_pulse <= 1'b0;
            rd_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (psel && !penable) begin
                        idx_q   <= setup_idx;
                        write_q <= pwrite;
                        wdata_q <= pwdata;
                        err_q   <= setup_err;
                        cnt     <= WAIT_V;
                        if (!pwrite) begin
                            prdata <= setup_err ? '0 : mem[setup_idx];
                        end
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!psel) begin
                        state <= S_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (penable) begin
                        if (write_q) begin
                            if (!err_q) begin
                                mem[idx_q] <= wdata_q;
                                wr_pulse   <= 1'b1;
                            end
                        end else begin
                            rd_pulse <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
